// File: rtl/forward_hazard_unit_pkg.sv
// Shared constants and helpers for the EX-stage forwarding / load-use hazard unit.
package forward_hazard_unit_pkg;

    // ALU operand mux data-port indices
    localparam logic [1:0] FWD_SEL_RF  = 2'd0;  // register-file value
    localparam logic [1:0] FWD_SEL_WB  = 2'd1;  // MEM/WB write-back data
    localparam logic [1:0] FWD_SEL_MEM = 2'd2;  // EX/MEM ALU result

    // Architectural $zero: never a forwarding source, never a hazard
    localparam int unsigned REG_ZERO = 0;

    // Priority select: the younger producer (MEM) wins over WB
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        case ({mem_hit, wb_hit})
            2'b10, 2'b11: sel = FWD_SEL_MEM;
            2'b01:        sel = FWD_SEL_WB;
            default:      sel = FWD_SEL_RF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/forward_hazard_unit_rec.sv
// Pipeline stage record: W-bit register with async reset, hold enable and
// synchronous clear used to inject an all-zero bubble (NOP).
module fwd_stage_rec #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next record: hold when disabled, bubble when cleared, else capture input
    always_comb begin
        q_d = q_q;
        if (!en_i) begin
            q_d = q_q;
        end else if (clr_i) begin
            q_d = {W{1'b0}};
        end else begin
            q_d = d_i;
        end
    end

    // Record storage, reset to NOP
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand-forwarding and load-use hazard controller for a 5-stage MIPS pipeline.
// Keeps its own EX/MEM/WB destination records and drives the EX operand mux
// selects plus the PC/IF-ID stall and ID/EX bubble controls.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  freeze_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] id_dst_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic                  stall_o,
    output logic                  bubble_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int unsigned EX_W  = 3 * REG_ADDR_W + 3;
    localparam int unsigned MEM_W = REG_ADDR_W + 2;
    localparam int unsigned WB_W  = REG_ADDR_W + 1;
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);

    // ---------------------------------------------------------------
    // Stage records
    // ---------------------------------------------------------------
    logic [EX_W-1:0]  ex_d,  ex_q;
    logic [MEM_W-1:0] mem_d, mem_q;
    logic [WB_W-1:0]  wb_d,  wb_q;

    logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic                  ex_uses_rt, ex_regwrite, ex_memread;
    logic                  mem_regwrite, mem_memread, wb_regwrite;

    logic haz_s;
    logic adv_s;

    assign adv_s = ~freeze_i;

    assign ex_d  = {id_rs_i, id_rt_i, id_uses_rt_i, id_dst_i, id_regwrite_i, id_memread_i};
    assign mem_d = {ex_dst, ex_regwrite, ex_memread};
    assign wb_d  = {mem_dst, mem_regwrite};

    assign {ex_rs, ex_rt, ex_uses_rt, ex_dst, ex_regwrite, ex_memread} = ex_q;
    assign {mem_dst, mem_regwrite, mem_memread}                        = mem_q;
    assign {wb_dst, wb_regwrite}                                       = wb_q;

    fwd_stage_rec #(.W(EX_W)) u_ex_rec (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (adv_s),
        .clr_i (haz_s),
        .d_i   (ex_d),
        .q_o   (ex_q)
    );

    fwd_stage_rec #(.W(MEM_W)) u_mem_rec (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (adv_s),
        .clr_i (1'b0),
        .d_i   (mem_d),
        .q_o   (mem_q)
    );

    fwd_stage_rec #(.W(WB_W)) u_wb_rec (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (adv_s),
        .clr_i (1'b0),
        .d_i   (wb_d),
        .q_o   (wb_q)
    );

    // ---------------------------------------------------------------
    // Load-use hazard: the load in EX feeds a source of the ID instruction
    // ---------------------------------------------------------------
    logic ex_load_live_s;

    // Detect a load in EX whose non-$zero destination is read by ID
    always_comb begin
        ex_load_live_s = ex_memread & ex_regwrite & (ex_dst != ZERO_ADDR);
        haz_s          = 1'b0;
        if (ex_load_live_s) begin
            haz_s = (ex_dst == id_rs_i) | (id_uses_rt_i & (ex_dst == id_rt_i));
        end else begin
            haz_s = 1'b0;
        end
    end

    assign stall_o  = haz_s & ~freeze_i;
    assign bubble_o = haz_s & ~freeze_i;

    // ---------------------------------------------------------------
    // Forwarding selects for the instruction currently in EX
    // ---------------------------------------------------------------
    logic mem_src_s, wb_src_s;
    logic a_mem_hit_s, a_wb_hit_s, b_mem_hit_s, b_wb_hit_s;

    // Compare producer records against the EX sources; load data never comes from MEM
    always_comb begin
        mem_src_s   = mem_regwrite & ~mem_memread & (mem_dst != ZERO_ADDR);
        wb_src_s    = wb_regwrite & (wb_dst != ZERO_ADDR);
        a_mem_hit_s = mem_src_s & (mem_dst == ex_rs);
        a_wb_hit_s  = wb_src_s  & (wb_dst  == ex_rs);
        b_mem_hit_s = ex_uses_rt & mem_src_s & (mem_dst == ex_rt);
        b_wb_hit_s  = ex_uses_rt & wb_src_s  & (wb_dst  == ex_rt);
        fwd_a_sel_o = fwd_select(a_mem_hit_s, a_wb_hit_s);
        fwd_b_sel_o = fwd_select(b_mem_hit_s, b_wb_hit_s);
    end

    // ---------------------------------------------------------------
    // Saturating stall-cycle counter
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count unfrozen hazard cycles, sticking at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze_i) begin
            stall_cnt_d = stall_cnt_q;
        end else if (haz_s && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter register, cleared by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: two instances (16-bit and 2-bit
// stall counters) share stimulus; expectations are queued as each ID
// instruction is driven and popped when the outputs are sampled.
module tb_forward_hazard_unit;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       u;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic        st;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_uses_rt, id_regwrite, id_memread;
    logic [1:0]  a_sel, b_sel, a2_sel, b2_sel;
    logic        stall, bubble, stall2, bubble2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    exp_t        sb_q[$];
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt2;
    int          n_assert;
    int          n_fail;

    forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .freeze_i(freeze),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .id_dst_i(id_dst), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .fwd_a_sel_o(a_sel), .fwd_b_sel_o(b_sel),
        .stall_o(stall), .bubble_o(bubble), .stall_cnt_o(cnt)
    );

    forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .freeze_i(freeze),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .id_dst_i(id_dst), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .fwd_a_sel_o(a2_sel), .fwd_b_sel_o(b2_sel),
        .stall_o(stall2), .bubble_o(bubble2), .stall_cnt_o(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(input int rs, input int rt, input int u,
                                  input int dst, input int rw, input int mr);
        instr_t t;
        t.rs = rs[4:0]; t.rt = rt[4:0]; t.u = u[0];
        t.dst = dst[4:0]; t.rw = rw[0]; t.mr = mr[0];
        return t;
    endfunction

    function automatic logic [29:0] obs_vec();
        return {a_sel, b_sel, stall, bubble, cnt, a2_sel, b2_sel, stall2, bubble2, cnt2};
    endfunction

    function automatic logic [29:0] exp_vec(input exp_t e);
        return {e.a, e.b, e.st, e.st, e.cnt, e.a, e.b, e.st, e.st, e.cnt2};
    endfunction

    function automatic string obs_str();
        return $sformatf("a=%0d b=%0d stall=%0b bubble=%0b cnt=%0d | a2=%0d b2=%0d stall2=%0b bubble2=%0b cnt2=%0d",
                         a_sel, b_sel, stall, bubble, cnt, a2_sel, b2_sel, stall2, bubble2, cnt2);
    endfunction

    function automatic string exp_str(input exp_t e);
        return $sformatf("a=%0d b=%0d stall=bubble=%0b cnt=%0d cnt2=%0d", e.a, e.b, e.st, e.cnt, e.cnt2);
    endfunction

    // Drive one ID instruction for a cycle, queue its expectation, settle
    task automatic drive(input instr_t ins, input logic frz,
                         input logic [1:0] ea, input logic [1:0] eb, input logic est);
        exp_t e;
        @(negedge clk);
        id_rs = ins.rs; id_rt = ins.rt; id_uses_rt = ins.u;
        id_dst = ins.dst; id_regwrite = ins.rw; id_memread = ins.mr;
        freeze = frz;
        e.a = ea; e.b = eb; e.st = est; e.cnt = exp_cnt; e.cnt2 = exp_cnt2;
        sb_q.push_back(e);
        if (est) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        freeze = 1'b0;
        {id_rs, id_rt, id_uses_rt, id_dst, id_regwrite, id_memread} = 18'd0;
        #2;
        rst = 1'b0;
        exp_cnt = 16'd0;
        exp_cnt2 = 2'd0;
    endtask

    // Power-on reset, then an async reset pulse in the middle of a stall
    task automatic test_reset();
        exp_t   e;
        instr_t ins [4];
        logic [1:0] ea [4];
        logic [1:0] eb [4];
        logic       est [4];
        #1;
        e = '{a: 2'd0, b: 2'd0, st: 1'b0, cnt: 16'd0, cnt2: 2'd0};
        sb_q.push_back(e);
        e = sb_q.pop_front();
        n_assert++;
        if (obs_vec() !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL reset_initial: got %s, expected %s", obs_str(), exp_str(e));
        end
        rst = 1'b0;
        exp_cnt = 16'd0;
        exp_cnt2 = 2'd0;
        ins = '{mk(1,0,0,5,1,1), mk(5,0,0,7,1,0), mk(1,0,0,6,1,1), mk(6,0,0,7,1,0)};
        ea  = '{2'd0, 2'd0, 2'd0, 2'd0};
        eb  = '{2'd0, 2'd0, 2'd0, 2'd0};
        est = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(ins[i], 1'b0, ea[i], eb[i], est[i]);
            e = sb_q.pop_front();
            n_assert++;
            if (obs_vec() !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL reset_pre[%0d]: got %s, expected %s", i, obs_str(), exp_str(e));
            end
        end
        // stall is active with cnt=1; hit reset between clock edges
        rst = 1'b1;
        exp_cnt = 16'd0;
        exp_cnt2 = 2'd0;
        #1;
        e = '{a: 2'd0, b: 2'd0, st: 1'b0, cnt: 16'd0, cnt2: 2'd0};
        sb_q.push_back(e);
        e = sb_q.pop_front();
        n_assert++;
        if (obs_vec() !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL reset_async: got %s, expected %s", obs_str(), exp_str(e));
        end
        #1;
        rst = 1'b0;
        drive(mk(0,0,0,0,0,0), 1'b0, 2'd0, 2'd0, 1'b0);
        e = sb_q.pop_front();
        n_assert++;
        if (obs_vec() !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL reset_post: got %s, expected %s", obs_str(), exp_str(e));
        end
    endtask

    // EX/MEM forwarding: add $3 then sub rs=$3
    task automatic test_ex_forward();
        exp_t   e;
        instr_t ins [3];
        logic [1:0] ea [3];
        logic [1:0] eb [3];
        apply_reset();
        ins = '{mk(1,2,1,3,1,0), mk(3,7,1,8,1,0), mk(0,0,0,0,0,0)};
        ea  = '{2'd0, 2'd0, 2'd2};
        eb  = '{2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], 1'b0, ea[i], eb[i], 1'b0);
            e = sb_q.pop_front();
            n_assert++;
            if (obs_vec() !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL ex_forward[%0d]: got %s, expected %s", i, obs_str(), exp_str(e));
            end
        end
    endtask

    // MEM/WB forwarding two ahead, then MEM-over-WB priority on $4
    task automatic test_wb_forward();
        exp_t   e;
        instr_t ins [8];
        logic [1:0] ea [8];
        logic [1:0] eb [8];
        apply_reset();
        ins = '{mk(1,1,0,4,1,0), mk(9,10,1,11,1,0), mk(4,4,1,12,1,0), mk(0,0,0,0,0,0),
                mk(0,0,0,4,1,0), mk(0,0,0,4,1,0), mk(4,4,1,13,1,0), mk(0,0,0,0,0,0)};
        ea  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2};
        eb  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2};
        for (int i = 0; i < 8; i++) begin
            drive(ins[i], 1'b0, ea[i], eb[i], 1'b0);
            e = sb_q.pop_front();
            n_assert++;
            if (obs_vec() !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL wb_forward[%0d]: got %s, expected %s", i, obs_str(), exp_str(e));
            end
        end
    endtask

    // lw $5 then add rt=$5; also a non-stall when rt matches but is unused
    task automatic test_load_use();
        exp_t   e;
        instr_t ins [7];
        logic [1:0] eb [7];
        logic       est [7];
        apply_reset();
        ins = '{mk(1,0,0,5,1,1), mk(2,5,1,6,1,0), mk(2,5,1,6,1,0), mk(0,0,0,0,0,0),
                mk(1,0,0,7,1,1), mk(3,7,0,8,1,0), mk(0,0,0,0,0,0)};
        eb  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        est = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(ins[i], 1'b0, 2'd0, eb[i], est[i]);
            e = sb_q.pop_front();
            n_assert++;
            if (obs_vec() !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %s, expected %s", i, obs_str(), exp_str(e));
            end
        end
    endtask

    // $zero as load target, as source and as ALU destination
    task automatic test_zero_reg();
        exp_t   e;
        instr_t ins [5];
        apply_reset();
        ins = '{mk(1,0,0,0,1,1), mk(0,0,1,9,1,0), mk(0,0,1,0,1,0),
                mk(0,0,1,14,1,0), mk(0,0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            drive(ins[i], 1'b0, 2'd0, 2'd0, 1'b0);
            e = sb_q.pop_front();
            n_assert++;
            if (obs_vec() !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL zero_reg[%0d]: got %s, expected %s", i, obs_str(), exp_str(e));
            end
        end
    endtask

    // Freeze across a load-use hazard, then repeated stalls to saturate the 2-bit counter
    task automatic test_freeze_saturate();
        exp_t   e;
        instr_t ins [7];
        logic       frz [7];
        logic [1:0] eb [7];
        logic       est [7];
        apply_reset();
        ins = '{mk(1,0,0,5,1,1), mk(2,5,1,6,1,0), mk(2,5,1,6,1,0), mk(2,5,1,6,1,0),
                mk(2,5,1,6,1,0), mk(2,5,1,6,1,0), mk(0,0,0,0,0,0)};
        frz = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        eb  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        est = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(ins[i], frz[i], 2'd0, eb[i], est[i]);
            e = sb_q.pop_front();
            n_assert++;
            if (obs_vec() !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL freeze[%0d]: got %s, expected %s", i, obs_str(), exp_str(e));
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 3; i < 7; i++) begin
                drive((i == 3) ? ins[0] : ins[i], 1'b0, 2'd0, eb[i], est[i]);
                e = sb_q.pop_front();
                n_assert++;
                if (obs_vec() !== exp_vec(e)) begin
                    n_fail++;
                    $display("FAIL saturate[%0d.%0d]: got %s, expected %s", k, i, obs_str(), exp_str(e));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst = 1'b1;
        freeze = 1'b0;
        {id_rs, id_rt, id_uses_rt, id_dst, id_regwrite, id_memread} = 18'd0;
        exp_cnt = 16'd0;
        exp_cnt2 = 2'd0;
        test_reset();
        test_ex_forward();
        test_wb_forward();
        test_load_use();
        test_zero_reg();
        test_freeze_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
